hci_hwpe_arbiter: RTL and testbench

- Shares one wide HWPE core port between NB_REQ HWPE initiators (streamers, DMA-like engines) in front of the word-interleaved HWPE interconnect.
- Arbitration is round-robin with burst locking: an owner keeps the port for up to MAX_BURST consecutive granted transactions.
- Routes the single-cycle-latency responses (r_valid/r_data) back to the initiator granted in the previous cycle.

---
 rtl/hci_hwpe_arbiter_pkg.sv | 11 +
 rtl/hci_rr_select.sv | 28 ++
 rtl/hci_hwpe_arbiter.sv | 113 +++++++++++
 tb/tb_hci_hwpe_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hci_hwpe_arbiter_pkg.sv
// hci_hwpe_arbiter_pkg: shared defaults, arbiter state type and round-robin pointer helper.
package hci_hwpe_arbiter_pkg;
  localparam int DEFAULT_DW = 32;
  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_BW = 8;
  localparam int DEFAULT_UW = 1;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int rr_next(input int ptr, input int nb);
    return (ptr + 1 >= nb) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/hci_rr_select.sv
// hci_rr_select: first requester at or after a start pointer, searched cyclically.
module hci_rr_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    logic [IW:0] j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr_i} + (IW+1)'(k);
      j = j >= (IW+1)'(N) ? j - (IW+1)'(N) : j;
      if (!valid_o && req_i[j[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = j[IW-1:0];
        gnt_o   = N'(1) << j[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/hci_hwpe_arbiter.sv
// hci_hwpe_arbiter: round-robin, burst-locking share of one HWPE core port among NB_REQ initiators.
// Optional per-port stall counters enabled by HCI_HWPE_ARBITER_PERF_EN.
module hci_hwpe_arbiter
  import hci_hwpe_arbiter_pkg::*;
#(
  parameter int NB_REQ    = 2,
  parameter int MAX_BURST = 4,
  parameter int DW        = DEFAULT_DW,
  parameter int AW        = DEFAULT_AW,
  parameter int BW        = DEFAULT_BW,
  parameter int UW        = DEFAULT_UW,
  localparam int IW       = NB_REQ > 1 ? $clog2(NB_REQ) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic [NB_REQ-1:0]                in_req_i,
  input  logic [NB_REQ-1:0][AW-1:0]        in_add_i,
  input  logic [NB_REQ-1:0]                in_wen_i,
  input  logic [NB_REQ-1:0][DW/BW-1:0]     in_be_i,
  input  logic [NB_REQ-1:0][DW-1:0]        in_data_i,
  input  logic [NB_REQ-1:0][UW-1:0]        in_user_i,
  output logic [NB_REQ-1:0]                in_gnt_o,
  output logic [NB_REQ-1:0]                in_r_valid_o,
  output logic [DW-1:0]                    in_r_data_o,
  output logic [UW-1:0]                    in_r_user_o,
  output logic                             out_req_o,
  output logic [AW-1:0]                    out_add_o,
  output logic                             out_wen_o,
  output logic [DW/BW-1:0]                 out_be_o,
  output logic [DW-1:0]                    out_data_o,
  output logic [UW-1:0]                    out_user_o,
  input  logic                             out_gnt_i,
  input  logic                             out_r_valid_i,
  input  logic [DW-1:0]                    out_r_data_i,
  output logic [IW-1:0]                    owner_o,
  output logic                             locked_o
`ifdef HCI_HWPE_ARBITER_PERF_EN
  , output logic [NB_REQ-1:0][31:0]        stall_cnt_o
`endif
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  arb_state_e          state_q;
  logic [IW-1:0]       owner_q, rr_ptr_q, resp_sel_q, sel, rr_idx, start;
  logic [CW-1:0]       burst_q, burst_eff;
  logic                resp_pend_q, hold, rr_valid, hs, others, last;
  logic [NB_REQ-1:0]   rr_gnt, sel_oh;
  // A locked owner that drops req hands over in the same cycle, searching from owner+1.
  assign hold  = state_q == LOCKED && in_req_i[owner_q];
  assign start = state_q == LOCKED ? IW'(rr_next(int'(owner_q), NB_REQ)) : rr_ptr_q;
  hci_rr_select #(.N(NB_REQ), .IW(IW)) u_sel (
    .req_i   (in_req_i),
    .ptr_i   (start),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );
  assign sel        = hold ? owner_q : rr_idx;
  assign sel_oh     = hold ? NB_REQ'(1) << owner_q : rr_gnt;
  assign out_req_o  = hold | rr_valid;
  assign out_add_o  = in_add_i[sel];
  assign out_wen_o  = in_wen_i[sel];
  assign out_be_o   = in_be_i[sel];
  assign out_data_o = in_data_i[sel];
  assign out_user_o = in_user_i[sel];
  assign hs         = out_req_o & out_gnt_i;
  assign others     = |(in_req_i & ~sel_oh);
  assign burst_eff  = hold ? burst_q : '0;
  assign last       = burst_eff == CW'(MAX_BURST - 1);
  assign in_r_data_o = out_r_data_i;
  assign in_r_user_o = '0;
  assign owner_o     = owner_q;
  assign locked_o    = state_q == LOCKED;
  for (genvar g = 0; g < NB_REQ; g++) begin : g_port
    assign in_gnt_o[g]     = ~rst_i & out_gnt_i & in_req_i[g] & sel_oh[g];
    assign in_r_valid_o[g] = ~rst_i & out_r_valid_i & resp_pend_q & (resp_sel_q == IW'(g));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_q     <= '0;
      resp_pend_q <= 1'b0;
      resp_sel_q  <= '0;
    end else begin
      resp_pend_q <= hs;
      if (hs) begin
        resp_sel_q <= sel;
        owner_q    <= sel;
        burst_q    <= last ? '0 : burst_eff + 1'b1;
        state_q    <= last && others ? IDLE : LOCKED;
        if (last && others) rr_ptr_q <= IW'(rr_next(int'(sel), NB_REQ));
      end else if (state_q == LOCKED && !in_req_i[owner_q]) begin
        state_q  <= IDLE;
        burst_q  <= '0;
        rr_ptr_q <= IW'(rr_next(int'(owner_q), NB_REQ));
      end
    end
  end
`ifdef HCI_HWPE_ARBITER_PERF_EN
  logic [31:0] stall_q [NB_REQ];
  logic [31:0] stall_d [NB_REQ];
  for (genvar g = 0; g < NB_REQ; g++) begin : g_stall
    assign stall_d[g]     = in_req_i[g] && !in_gnt_o[g] && !(&stall_q[g]) ? stall_q[g] + 1 : stall_q[g];
    assign stall_cnt_o[g] = stall_q[g];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) stall_q <= '{default: '0};
    else stall_q <= stall_d;
  end
`endif
endmodule

// File: tb/tb_hci_hwpe_arbiter.sv
// tb_hci_hwpe_arbiter: directed checks of grant rotation, burst lock, back-pressure, handover and clear.
module tb_hci_hwpe_arbiter;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
  always #5 clk = ~clk;
  logic [1:0]         req;
  logic [1:0][31:0]   add;
  logic [1:0]         wen;
  logic [1:0][3:0]    be;
  logic [1:0][31:0]   data;
  logic [1:0][0:0]    user;
  logic [1:0]         in_gnt, in_r_valid;
  logic [31:0]        in_r_data, out_add, out_data, out_r_data;
  logic [0:0]         in_r_user, out_user;
  logic               out_req, out_wen, out_gnt, out_r_valid;
  logic [3:0]         out_be;
  logic [0:0]         owner;
  logic               locked;
`ifdef HCI_HWPE_ARBITER_PERF_EN
  logic [1:0][31:0]   stall;
`endif
  int n_chk = 0, n_pass = 0;
  logic [1:0] exp_rr [9]   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
  logic [1:0] exp_bp [4]   = '{2'b01, 2'b01, 2'b01, 2'b10};
  logic [1:0] exp_dr [4]   = '{2'b10, 2'b10, 2'b10, 2'b01};
  logic [1:0] perf_req [9] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11};

  hci_hwpe_arbiter dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_req_i(req), .in_add_i(add), .in_wen_i(wen), .in_be_i(be), .in_data_i(data), .in_user_i(user),
    .in_gnt_o(in_gnt), .in_r_valid_o(in_r_valid), .in_r_data_o(in_r_data), .in_r_user_o(in_r_user),
    .out_req_o(out_req), .out_add_o(out_add), .out_wen_o(out_wen), .out_be_o(out_be),
    .out_data_o(out_data), .out_user_o(out_user), .out_gnt_i(out_gnt), .out_r_valid_i(out_r_valid),
    .out_r_data_i(out_r_data), .owner_o(owner), .locked_o(locked)
`ifdef HCI_HWPE_ARBITER_PERF_EN
    , .stall_cnt_o(stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input logic [1:0] r, input logic g, input logic rv);
    @(posedge clk);
    #1;
    req = r; out_gnt = g; out_r_valid = rv;
    #3;
  endtask

  initial begin
    req = 2'b11; out_gnt = 1'b1; out_r_valid = 1'b1; out_r_data = 32'hA1;
    add = '{32'h0, 32'h200}; wen = 2'b00; be = '{4'hF, 4'h3}; data = '{32'h0, 32'h5555}; user = '0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_gnt", in_gnt, 2'b00);
    chk("rst_rvalid", in_r_valid, 2'b00);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b0; req = 2'b00;
    // single initiator on port 1
    add[1] = 32'h100; wen[1] = 1'b1; data[1] = 32'hDEAD;
    cyc(2'b10, 1, 0);
    chk("t1_req", out_req, 1);
    chk("t1_add0", out_add, 32'h100);
    chk("t1_data", out_data, 32'hDEAD);
    chk("t1_wen", out_wen, 1);
    chk("t1_gnt0", in_gnt, 2'b10);
    chk("t1_lock0", locked, 0);
    add[1] = 32'h110;
    cyc(2'b10, 1, 1);
    chk("t1_gnt1", in_gnt, 2'b10);
    chk("t1_rv1", in_r_valid, 2'b10);
    chk("t1_owner", owner, 1);
    chk("t1_lock1", locked, 1);
    chk("t1_add1", out_add, 32'h110);
    chk("t1_rdata", in_r_data, 32'hA1);
    add[1] = 32'h120;
    cyc(2'b10, 1, 1);
    chk("t1_gnt2", in_gnt, 2'b10);
    chk("t1_rv2", in_r_valid, 2'b10);
    chk("t1_add2", out_add, 32'h120);
    cyc(2'b00, 1, 1);
    chk("t1_rv3", in_r_valid, 2'b10);
    chk("t1_gnt3", in_gnt, 2'b00);
    chk("t1_noreq", out_req, 0);
    cyc(2'b00, 1, 1);
    chk("t1_drop_rv", in_r_valid, 2'b00);
    chk("t1_idle", locked, 0);
    chk("t1_owner_keep", owner, 1);
    // contention: four grants per owner, then rotate
    for (int i = 0; i < 9; i++) begin
      cyc(2'b11, 1, 0);
      chk($sformatf("t2_gnt%0d", i), in_gnt, exp_rr[i]);
      if (i == 2) chk("t2_lock", locked, 1);
    end
    // back-pressure mid-burst freezes the burst count
    for (int i = 0; i < 5; i++) begin
      cyc(2'b11, 0, 0);
      chk($sformatf("t3_nogrant%0d", i), in_gnt, 2'b00);
      if (i == 4) begin
        chk("t3_owner", owner, 0);
        chk("t3_lock", locked, 1);
        chk("t3_add", out_add, 32'h200);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 1, 0);
      chk($sformatf("t3_resume%0d", i), in_gnt, exp_bp[i]);
    end
    // owner drop: same-cycle handover with a fresh burst
    cyc(2'b00, 1, 0);
    cyc(2'b01, 1, 0);
    chk("t4_pre0", in_gnt, 2'b01);
    cyc(2'b01, 1, 0);
    chk("t4_pre1", in_gnt, 2'b01);
    cyc(2'b10, 1, 0);
    chk("t4_handover", in_gnt, 2'b10);
    chk("t4_add", out_add, 32'h120);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 1, 0);
      chk($sformatf("t4_gnt%0d", i), in_gnt, exp_dr[i]);
      if (i == 0) chk("t4_owner", owner, 1);
    end
    // clear together with a handshake suppresses its response and resets the pointer
    cyc(2'b00, 1, 0);
    cyc(2'b10, 1, 0);
    clear = 1'b1;
    chk("t5_gnt", in_gnt, 2'b10);
    out_r_data = 32'hB2;
    cyc(2'b00, 1, 1);
    clear = 1'b0;
    chk("t5_rv", in_r_valid, 2'b00);
    chk("t5_owner", owner, 0);
    chk("t5_lock", locked, 0);
    chk("t5_rdata", in_r_data, 32'hB2);
    cyc(2'b11, 1, 0);
    chk("t5_ptr", in_gnt, 2'b01);
`ifdef HCI_HWPE_ARBITER_PERF_EN
    cyc(2'b00, 0, 0);
    clear = 1'b1;
    cyc(2'b00, 0, 0);
    clear = 1'b0;
    chk("t6_clr1", stall[1], 0);
    for (int i = 0; i < 9; i++) begin
      cyc(perf_req[i], 1, 0);
      chk($sformatf("t6_gnt%0d", i), in_gnt, 2'b01);
    end
    cyc(2'b00, 1, 0);
    chk("t6_stall0", stall[0], 0);
    chk("t6_stall1", stall[1], 7);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
